video_window_gen: RTL and testbench

Parametrised vertical-region and video-mix generator for the discrete-logic arcade recreations. It takes the frame's vertical count, HSYNC and the vertical-reset pulse, and produces:
- the star window (`V_WINDOW`) and score band (`STAR_BLANK`);
- the rocket-reset pulse (`R_RESET`) and bottom-bound level (`R_BBOUND`);
- the merged video and score lines (`VIDEO`, `SCORE`).

It sits between the sync/counter chain and the final video DAC mix. It supersedes the fixed 8-bit, 2-source version by generalising count width, region boundaries and source count, and by registering every output glitch-free on `CLK_DRV`.

---
 rtl/video_pkg.sv | 12 +
 rtl/vwin_edge_sample.sv | 30 +++
 rtl/video_window_gen.sv | 103 ++++++++++
 tb/tb_video_window_gen.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared defaults and window-latch encoding for the video window/mix generator.
package video_pkg;

    localparam int VBITS_D      = 9;
    localparam int WIN_END_D    = 224;
    localparam int BAND_START_D = 224;
    localparam int RLO_D        = 248;
    localparam int RHI_D        = 255;

    typedef enum logic {WIN_CLOSED = 1'b0, WIN_OPEN = 1'b1} win_t;

endpackage

// File: rtl/vwin_edge_sample.sv
// HSYNC rising-edge detector driving an edge-enabled D register.
// q_next exposes the value q will take at the coming edge.
module vwin_edge_sample
    import video_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic hsync,
    input  logic d,
    output logic q_next,
    output logic q
);

    logic hs_q;
    logic hs_rise;

    assign hs_rise = hsync & ~hs_q;
    assign q_next  = hs_rise ? d : q;

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q <= 1'b0;
            q    <= 1'b0;
        end else begin
            hs_q <= hsync;
            q    <= q_next;
        end
    end

endmodule

// File: rtl/video_window_gen.sv
// Vertical-region and video-mix generator; every output registered on CLK_DRV.
// Build option VWIN_SCORE_PRIO_EN: score blanks playfield video when both are active.
//
// state      | meaning
// WIN_CLOSED | past WIN_END (or after reset); rocket region may be active
// WIN_OPEN   | from frame start (VRESET_N low) until VCNT reaches WIN_END
module video_window_gen
    import video_pkg::*;
#(
    parameter int VBITS      = VBITS_D,
    parameter int NSRC       = 2,
    parameter int NSCR       = 2,
    parameter int WIN_END    = WIN_END_D,
    parameter int BAND_START = BAND_START_D,
    parameter int RLO        = RLO_D,
    parameter int RHI        = RHI_D
) (
    input  logic             CLK_DRV,
    input  logic             RESET,
    input  logic             HSYNC,
    input  logic             VRESET_N,
    input  logic [VBITS-1:0] VCNT,
    input  logic [NSRC-1:0]  VID_N,
    input  logic [NSCR-1:0]  SCR_N,
    output logic             STAR_BLANK,
    output logic             V_WINDOW,
    output logic             R_RESET,
    output logic             R_BBOUND,
    output logic             VIDEO,
    output logic             SCORE
);

    localparam logic [0:0] ST_CLOSED = WIN_CLOSED;
    localparam logic [0:0] ST_OPEN   = WIN_OPEN;

    localparam logic [VBITS-1:0] WIN_END_V    = VBITS'(WIN_END);
    localparam logic [VBITS-1:0] BAND_START_V = VBITS'(BAND_START);
    localparam logic [VBITS-1:0] BAND_TOP_V   = VBITS'(255);
    localparam logic [VBITS-1:0] RLO_V        = VBITS'(RLO);
    localparam logic [VBITS-1:0] RHI_V        = VBITS'(RHI);

    logic [0:0] win_q;
    logic [0:0] win_d;
    logic       in_r;
    logic       bb;
    logic       bb_next;
    logic       star_d;
    logic       vid_any;
    logic       scr_any;
    logic       video_d;

    // Frame start dominates a simultaneous close condition.
    always_comb begin
        win_d = win_q;
        if (!VRESET_N) begin
            win_d = ST_OPEN;
        end else if (win_q == ST_OPEN && VCNT >= WIN_END_V) begin
            win_d = ST_CLOSED;
        end
    end

    assign in_r   = (win_q == ST_CLOSED) && (VCNT >= RLO_V) && (VCNT <= RHI_V);
    assign star_d = (VCNT >= BAND_START_V) && (VCNT <= BAND_TOP_V);

    vwin_edge_sample u_bb (
        .clk    (CLK_DRV),
        .reset  (RESET),
        .hsync  (HSYNC),
        .d      (in_r),
        .q_next (bb_next),
        .q      (bb)
    );

    assign vid_any = |(~VID_N);
    assign scr_any = |(~SCR_N);

`ifdef VWIN_SCORE_PRIO_EN
    assign video_d = vid_any & ~scr_any;
`else
    assign video_d = vid_any;
`endif

    // Using bb_next suppresses the pulse when hs_rise lands on the first region cycle.
    always_ff @(posedge CLK_DRV) begin
        if (RESET) begin
            win_q      <= ST_CLOSED;
            R_RESET    <= 1'b0;
            STAR_BLANK <= 1'b0;
            VIDEO      <= 1'b0;
            SCORE      <= 1'b0;
        end else begin
            win_q      <= win_d;
            R_RESET    <= in_r & ~bb_next;
            STAR_BLANK <= star_d;
            VIDEO      <= video_d;
            SCORE      <= scr_any;
        end
    end

    assign V_WINDOW = (win_q == ST_OPEN);
    assign R_BBOUND = bb;

endmodule

// File: tb/tb_video_window_gen.sv
// Self-checking bench for video_window_gen: directed scenarios plus random
// stimulus compared each cycle against a line/frame-level reference model.
module tb_video_window_gen;

    localparam int WIN_END    = 224;
    localparam int BAND_START = 224;
    localparam int RLO        = 248;
    localparam int RHI        = 255;

    logic       CLK_DRV;
    logic       RESET;
    logic       HSYNC;
    logic       VRESET_N;
    logic [8:0] VCNT;
    logic [1:0] VID_N;
    logic [1:0] SCR_N;
    logic       STAR_BLANK, V_WINDOW, R_RESET, R_BBOUND, VIDEO, SCORE;

    logic [5:0] obs;
    assign obs = {V_WINDOW, STAR_BLANK, R_RESET, R_BBOUND, VIDEO, SCORE};

    // Reference model state: window open?, previous HSYNC, bottom-bound seen this region.
    bit         m_open, m_hs, m_bb;
    logic [5:0] exp_vec = '0;
    int         n_cmp = 0;
    int         n_bad = 0;

    video_window_gen dut (
        .CLK_DRV    (CLK_DRV),
        .RESET      (RESET),
        .HSYNC      (HSYNC),
        .VRESET_N   (VRESET_N),
        .VCNT       (VCNT),
        .VID_N      (VID_N),
        .SCR_N      (SCR_N),
        .STAR_BLANK (STAR_BLANK),
        .V_WINDOW   (V_WINDOW),
        .R_RESET    (R_RESET),
        .R_BBOUND   (R_BBOUND),
        .VIDEO      (VIDEO),
        .SCORE      (SCORE)
    );

    initial begin
        CLK_DRV = 1'b0;
        forever #5 CLK_DRV = ~CLK_DRV;
    end

    // Advance one clock; expected outputs follow from the inputs present at the edge.
    task automatic tick();
        bit hr, inr, bbn, vid, scr, star;
        int v;
        v = int'(VCNT);
        if (RESET) begin
            m_open  = 0;
            m_hs    = 0;
            m_bb    = 0;
            exp_vec = '0;
        end else begin
            hr   = HSYNC && !m_hs;
            inr  = !m_open && v >= RLO && v <= RHI;
            bbn  = hr ? inr : m_bb;
            star = v >= BAND_START && v <= 255;
            vid  = (VID_N != 2'b11);
            scr  = (SCR_N != 2'b11);
`ifdef VWIN_SCORE_PRIO_EN
            vid  = vid && !scr;
`endif
            if (!VRESET_N) m_open = 1;
            else if (m_open && v >= WIN_END) m_open = 0;
            m_hs    = HSYNC;
            m_bb    = bbn;
            exp_vec = {m_open, star, inr && !bbn, bbn, vid, scr};
        end
        @(posedge CLK_DRV);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1; VRESET_N = 1; HSYNC = 0; VCNT = '0; VID_N = 2'b11; SCR_N = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (obs !== 6'b0) begin
                n_bad++;
                $display("FAIL reset_outputs cyc=%0d got %b expected %b", i, obs, 6'b0);
            end
        end
        RESET = 0; VRESET_N = 0;
        tick();
        VRESET_N = 1;
        n_cmp++;
        if (V_WINDOW !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_vreset_open got %b expected 1", V_WINDOW);
        end
    endtask

    task automatic test_frame_sweep();
        int fall_line = -1;
        int star_cnt = 0, star_first = -1, star_last = -1;
        logic prev_win;
        prev_win = V_WINDOW;
        for (int l = 0; l <= 261; l++) begin
            for (int c = 0; c < 8; c++) begin
                VCNT     = 9'(l);
                HSYNC    = (c >= 3 && c < 5);
                VRESET_N = !(l == 0 && c == 0);
                tick();
                n_cmp++;
                if (obs !== exp_vec) begin
                    n_bad++;
                    $display("FAIL sweep line=%0d cyc=%0d got %b expected %b", l, c, obs, exp_vec);
                end
                if (prev_win && !V_WINDOW && fall_line < 0) fall_line = l;
                prev_win = V_WINDOW;
                if (STAR_BLANK) begin
                    star_cnt++;
                    if (star_first < 0) star_first = l;
                    star_last = l;
                end
            end
        end
        VRESET_N = 1;
        n_cmp++;
        if (fall_line != WIN_END) begin
            n_bad++;
            $display("FAIL sweep_window_fall got line %0d expected %0d", fall_line, WIN_END);
        end
        n_cmp++;
        if (star_first != BAND_START || star_last != 255 || star_cnt != (256 - BAND_START) * 8) begin
            n_bad++;
            $display("FAIL sweep_star_band got %0d..%0d cnt %0d expected %0d..255 cnt %0d",
                     star_first, star_last, star_cnt, BAND_START, (256 - BAND_START) * 8);
        end
    endtask

    task automatic test_rocket_line();
        int rr_cnt = 0, bb_rise = -1, bb_fall = -1;
        HSYNC = 0;
        VCNT = 9'd247;
        repeat (4) tick();
        VCNT = 9'd248;
        for (int c = 0; c < 16; c++) begin
            HSYNC = (c == 10 || c == 11);
            tick();
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL rocket_248 cyc=%0d got %b expected %b", c, obs, exp_vec);
            end
            if (R_RESET) rr_cnt++;
            if (R_BBOUND && bb_rise < 0) bb_rise = c;
        end
        n_cmp++;
        if (rr_cnt != 10) begin
            n_bad++;
            $display("FAIL rocket_rreset_len got %0d expected 10", rr_cnt);
        end
        n_cmp++;
        if (bb_rise != 10) begin
            n_bad++;
            $display("FAIL rocket_bbound_rise got cyc %0d expected 10", bb_rise);
        end
        for (int l = 249; l <= 256; l++) begin
            for (int c = 0; c < 8; c++) begin
                VCNT  = 9'(l);
                HSYNC = (c >= 3 && c < 5);
                tick();
                n_cmp++;
                if (obs !== exp_vec) begin
                    n_bad++;
                    $display("FAIL rocket_tail line=%0d cyc=%0d got %b expected %b", l, c, obs, exp_vec);
                end
                if (!R_BBOUND && bb_fall < 0) bb_fall = l * 8 + c;
            end
        end
        n_cmp++;
        if (bb_fall != 256 * 8 + 3) begin
            n_bad++;
            $display("FAIL rocket_bbound_fall got %0d expected %0d", bb_fall, 256 * 8 + 3);
        end
    endtask

    task automatic test_coincident();
        int rr_cnt = 0;
        HSYNC = 0;
        VCNT = 9'd247;
        repeat (4) tick();
        VCNT  = 9'd248;
        HSYNC = 1;
        for (int c = 0; c < 8; c++) begin
            if (c == 2) HSYNC = 0;
            tick();
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL coincident cyc=%0d got %b expected %b", c, obs, exp_vec);
            end
            if (R_RESET) rr_cnt++;
        end
        n_cmp++;
        if (rr_cnt != 0 || R_BBOUND !== 1'b1) begin
            n_bad++;
            $display("FAIL coincident_nopulse got rr=%0d bb=%b expected rr=0 bb=1", rr_cnt, R_BBOUND);
        end
    endtask

    task automatic test_vreset_collide();
        HSYNC = 0;
        VCNT = 9'd224; VRESET_N = 0;
        tick();
        n_cmp++;
        if (V_WINDOW !== 1'b1) begin
            n_bad++;
            $display("FAIL collide_from_closed got %b expected 1", V_WINDOW);
        end
        VCNT = 9'd10; VRESET_N = 1;
        repeat (3) tick();
        VCNT = 9'd224; VRESET_N = 0;
        tick();
        n_cmp++;
        if (V_WINDOW !== 1'b1 || obs !== exp_vec) begin
            n_bad++;
            $display("FAIL collide_open got %b expected %b", obs, exp_vec);
        end
        VRESET_N = 1;
        tick();
        n_cmp++;
        if (V_WINDOW !== 1'b0) begin
            n_bad++;
            $display("FAIL collide_then_close got %b expected 0", V_WINDOW);
        end
    endtask

    task automatic test_mix();
        logic exp_video;
`ifdef VWIN_SCORE_PRIO_EN
        exp_video = 1'b0;
`else
        exp_video = 1'b1;
`endif
        VID_N = 2'b10; SCR_N = 2'b01;
        tick();
        n_cmp++;
        if (VIDEO !== exp_video || SCORE !== 1'b1) begin
            n_bad++;
            $display("FAIL mix_both got video=%b score=%b expected video=%b score=1", VIDEO, SCORE, exp_video);
        end
        VID_N = 2'b11; SCR_N = 2'b11;
        tick();
        n_cmp++;
        if (VIDEO !== 1'b0 || SCORE !== 1'b0) begin
            n_bad++;
            $display("FAIL mix_idle got video=%b score=%b expected 0 0", VIDEO, SCORE);
        end
        for (int i = 0; i < 24; i++) begin
            VID_N = 2'($urandom_range(0, 3));
            SCR_N = 2'($urandom_range(0, 3));
            tick();
            n_cmp++;
            if (obs !== exp_vec) begin
                n_bad++;
                $display("FAIL mix_rand vid=%b scr=%b got %b expected %b", VID_N, SCR_N, obs, exp_vec);
            end
        end
        VID_N = 2'b11; SCR_N = 2'b11;
    endtask

    task automatic test_reset_midframe();
        bit win_seen = 0;
        VRESET_N = 0; VCNT = '0; HSYNC = 0;
        tick();
        VRESET_N = 1;
        VCNT = 9'd230;
        repeat (3) tick();
        for (int l = 248; l <= 250; l++) begin
            for (int c = 0; c < 6; c++) begin
                VCNT  = 9'(l);
                HSYNC = (c == 2);
                VID_N = 2'b01; SCR_N = 2'b10;
                if (l == 250 && c == 4) RESET = 1;
                tick();
                RESET = 0;
                if (l == 250 && c == 4) begin
                    n_cmp++;
                    if (obs !== 6'b0) begin
                        n_bad++;
                        $display("FAIL midreset_outputs got %b expected %b", obs, 6'b0);
                    end
                end
            end
        end
        for (int l = 251; l <= 261 + 6; l++) begin
            for (int c = 0; c < 6; c++) begin
                VCNT  = 9'(l % 262);
                HSYNC = (c == 2);
                tick();
                n_cmp++;
                if (obs !== exp_vec) begin
                    n_bad++;
                    $display("FAIL midreset_after line=%0d cyc=%0d got %b expected %b", l, c, obs, exp_vec);
                end
                if (V_WINDOW) win_seen = 1;
            end
        end
        n_cmp++;
        if (win_seen) begin
            n_bad++;
            $display("FAIL midreset_window_held got 1 expected 0 until vreset");
        end
        VRESET_N = 0;
        tick();
        VRESET_N = 1;
        n_cmp++;
        if (V_WINDOW !== 1'b1) begin
            n_bad++;
            $display("FAIL midreset_reopen got %b expected 1", V_WINDOW);
        end
    endtask

    task automatic test_random();
        int len;
        int line;
        line = 0;
        for (int i = 0; i < 600; i++) begin
            line = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 261)) : (line + 1) % 262;
            len  = int'($urandom_range(1, 6));
            for (int c = 0; c < len; c++) begin
                VCNT     = 9'(line);
                HSYNC    = 1'($urandom_range(0, 1));
                VRESET_N = ($urandom_range(0, 39) != 0);
                RESET    = ($urandom_range(0, 199) == 0);
                VID_N    = 2'($urandom_range(0, 3));
                SCR_N    = 2'($urandom_range(0, 3));
                tick();
                n_cmp++;
                if (obs !== exp_vec) begin
                    n_bad++;
                    $display("FAIL random it=%0d line=%0d got %b expected %b", i, line, obs, exp_vec);
                end
            end
        end
        RESET = 0; VRESET_N = 1;
    endtask

    initial begin
        RESET = 1; HSYNC = 0; VRESET_N = 1; VCNT = '0; VID_N = 2'b11; SCR_N = 2'b11;
        test_reset();
        test_frame_sweep();
        test_rocket_line();
        test_coincident();
        test_vreset_collide();
        test_mix();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
